// File: rtl/ft_telem_streamer.sv
// Multi-channel telemetry streamer for the FT write interface.
// Per-channel packet FIFOs are drained round-robin into framed bus words
// (one header word followed by the packet, MSB first). A loopback mode
// passes the FT read side straight back to the write side.
module ft_telem_streamer #(
    parameter int NUM_CH     = 2,
    parameter int PKT_W      = 88,
    parameter int BUS_W      = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int BE_W      = BUS_W / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH-1:0]       ch_valid,
    input  logic [NUM_CH*PKT_W-1:0] ch_data,
    input  logic [BUS_W-1:0]        lb_dout,
    input  logic [BE_W-1:0]         lb_dout_be,
    input  logic                    lb_dout_empty,
    output logic                    lb_dout_get,
    output logic [BUS_W-1:0]        ui_din,
    output logic [BE_W-1:0]         ui_din_be,
    output logic                    ui_din_valid,
    input  logic                    ui_din_full,
    input  logic                    clear_counters,
    output logic [31:0]             pkt_sent_count,
    output logic [15:0]             drop_count
);

    localparam int NW    = (PKT_W + BUS_W - 1) / BUS_W;
    localparam int PAD_W = NW * BUS_W;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOOP, S_HDR, S_BODY} state_t;

    state_t            r_state, w_nextState;
    logic [CH_W-1:0]   r_grant, w_grant, r_rrPtr;
    logic              w_grantFound;
    logic [IDX_W-1:0]  r_idx;

    logic [PKT_W-1:0]  r_mem   [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr [NUM_CH];
    logic [PTR_W-1:0]  r_rdPtr [NUM_CH];
    logic [PTR_W:0]    r_level [NUM_CH];
    logic [PTR_W:0]    r_ready [NUM_CH];
    logic [NUM_CH-1:0] r_pushDly, w_push, w_pop, w_drop;

    logic              w_lastAccept;
    logic [4:0]        w_dropNum;
    logic [16:0]       w_dropNext;
    logic [PKT_W-1:0]  w_headPkt;
    logic [PAD_W-1:0]  w_padded;

    // Final body word accepted: this is what retires the granted packet.
    assign w_lastAccept = (r_state == S_BODY) && !ui_din_full && (r_idx == LAST_IDX);

    // Capture decisions; a pop in the same cycle frees the slot, so no drop.
    always_comb begin
        w_push    = '0;
        w_pop     = '0;
        w_drop    = '0;
        w_dropNum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pop[i]  = w_lastAccept && (r_grant == CH_W'(i));
            w_push[i] = ch_valid[i] && ch_enable[i] && ((r_level[i] != FULL_LVL) || w_pop[i]);
            w_drop[i] = ch_valid[i] && ch_enable[i] && (r_level[i] == FULL_LVL) && !w_pop[i];
            w_dropNum = w_dropNum + 5'(w_drop[i]);
        end
        w_dropNext = {1'b0, drop_count} + 17'(w_dropNum);
    end

    // FIFO bookkeeping; r_ready lags pushes by a cycle so a fresh packet is
    // seen by the scheduler one cycle after it is stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_wrPtr[i] <= '0;
                r_rdPtr[i] <= '0;
                r_level[i] <= '0;
                r_ready[i] <= '0;
            end
            r_pushDly <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_push[i]) r_wrPtr[i] <= r_wrPtr[i] + 1'b1;
                if (w_pop[i])  r_rdPtr[i] <= r_rdPtr[i] + 1'b1;
                r_level[i] <= r_level[i] + (PTR_W+1)'(w_push[i]) - (PTR_W+1)'(w_pop[i]);
                r_ready[i] <= r_ready[i] + (PTR_W+1)'(r_pushDly[i]) - (PTR_W+1)'(w_pop[i]);
            end
            r_pushDly <= w_push;
        end
    end

    // Packet storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_push[i]) r_mem[i][r_wrPtr[i]] <= ch_data[i*PKT_W +: PKT_W];
        end
    end

    // Round-robin pick: first enabled channel with a ready packet at or after r_rrPtr.
    always_comb begin
        int c;
        w_grant      = '0;
        w_grantFound = 1'b0;
        c            = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (int'(r_rrPtr) + k) % NUM_CH;
            if (!w_grantFound && ch_enable[c] && (r_ready[c] != '0)) begin
                w_grantFound = 1'b1;
                w_grant      = CH_W'(c);
            end
        end
    end

    assign w_headPkt = r_mem[r_grant][r_rdPtr[r_grant]];
    assign w_padded  = PAD_W'(w_headPkt) << (PAD_W - PKT_W);

    // State register plus grant latch, word index and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_rrPtr <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_IDLE && w_nextState == S_HDR) r_grant <= w_grant;
            if (r_state == S_HDR && !ui_din_full) r_idx <= '0;
            else if (r_state == S_BODY && !ui_din_full) r_idx <= r_idx + 1'b1;
            if (w_lastAccept) r_rrPtr <= (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
        end
    end

    // Next-state and bus outputs; everything is zero unless a state drives it.
    always_comb begin
        w_nextState  = r_state;
        ui_din       = '0;
        ui_din_be    = '0;
        ui_din_valid = 1'b0;
        lb_dout_get  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mode == 2'd1) w_nextState = S_LOOP;
                else if (mode == 2'd2 && w_grantFound) w_nextState = S_HDR;
            end
            S_LOOP: begin
                if (mode == 2'd1) begin
                    ui_din       = lb_dout;
                    ui_din_be    = lb_dout_be;
                    ui_din_valid = !lb_dout_empty;
                    lb_dout_get  = !ui_din_full && !lb_dout_empty;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            S_HDR: begin
                ui_din       = BUS_W'({8'hA5, 8'(r_grant)});
                ui_din_be    = '1;
                ui_din_valid = 1'b1;
                if (!ui_din_full) w_nextState = S_BODY;
            end
            S_BODY: begin
                ui_din       = w_padded[(NW - 1 - int'(r_idx)) * BUS_W +: BUS_W];
                ui_din_be    = '1;
                ui_din_valid = 1'b1;
                if (w_lastAccept) w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Statistics counters; a clear wins over any increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_sent_count <= '0;
            drop_count     <= '0;
        end else if (clear_counters) begin
            pkt_sent_count <= '0;
            drop_count     <= '0;
        end else begin
            if (w_lastAccept) pkt_sent_count <= pkt_sent_count + 1'b1;
            drop_count <= w_dropNext[16] ? 16'hFFFF : w_dropNext[15:0];
        end
    end

endmodule

// File: tb/tb_ft_telem_streamer.sv
// Directed bench for ft_telem_streamer with the default 2 x 88-bit / 16-bit setup.
module tb_ft_telem_streamer;

    localparam int NUM_CH = 2;
    localparam int PKT_W  = 88;
    localparam int BUS_W  = 16;
    localparam int BE_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [1:0]              mode = 2'd0;
    logic [NUM_CH-1:0]       ch_enable = '0;
    logic [NUM_CH-1:0]       ch_valid = '0;
    logic [NUM_CH*PKT_W-1:0] ch_data = '0;
    logic [BUS_W-1:0]        lb_dout = '0;
    logic [BE_W-1:0]         lb_dout_be = '0;
    logic                    lb_dout_empty = 1'b1;
    logic                    lb_dout_get;
    logic [BUS_W-1:0]        ui_din;
    logic [BE_W-1:0]         ui_din_be;
    logic                    ui_din_valid;
    logic                    ui_din_full = 1'b0;
    logic                    clear_counters = 1'b0;
    logic [31:0]             pkt_sent_count;
    logic [15:0]             drop_count;

    int numChecks = 0;
    int numFails  = 0;

    localparam logic [87:0] PKT_T  = 88'h0123456789ABCDEF012345;
    localparam logic [95:0] PAD_T  = 96'h0123456789ABCDEF01234500;
    localparam logic [87:0] PKT_A  = 88'hA0A1A2A3A4A5A6A7A8A9AA;
    localparam logic [95:0] PAD_A  = 96'hA0A1A2A3A4A5A6A7A8A9AA00;
    localparam logic [87:0] PKT_B  = 88'hB0B1B2B3B4B5B6B7B8B9BA;
    localparam logic [95:0] PAD_B  = 96'hB0B1B2B3B4B5B6B7B8B9BA00;
    localparam logic [87:0] PKT_C  = 88'hC0C1C2C3C4C5C6C7C8C9CA;
    localparam logic [95:0] PAD_C  = 96'hC0C1C2C3C4C5C6C7C8C9CA00;
    localparam logic [87:0] PKT_D  = 88'hD0D1D2D3D4D5D6D7D8D9DA;
    localparam logic [95:0] PAD_D  = 96'hD0D1D2D3D4D5D6D7D8D9DA00;

    ft_telem_streamer #(.NUM_CH(2), .PKT_W(88), .BUS_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .ch_enable(ch_enable),
        .ch_valid(ch_valid), .ch_data(ch_data), .lb_dout(lb_dout),
        .lb_dout_be(lb_dout_be), .lb_dout_empty(lb_dout_empty),
        .lb_dout_get(lb_dout_get), .ui_din(ui_din), .ui_din_be(ui_din_be),
        .ui_din_valid(ui_din_valid), .ui_din_full(ui_din_full),
        .clear_counters(clear_counters), .pkt_sent_count(pkt_sent_count),
        .drop_count(drop_count)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] valid, input logic [NUM_CH*PKT_W-1:0] data);
        ch_valid = valid;
        ch_data  = data;
        stepCycle();
        ch_valid = '0;
    endtask

    task automatic expectPacket(input logic [7:0] grant, input logic [95:0] padded, input int holdWord);
        logic [15:0] expWord;
        for (int n = 0; n < 20 && !ui_din_valid; n++) stepCycle();
        for (int w = 0; w < 7; w++) begin
            expWord = (w == 0) ? {8'hA5, grant} : padded[95 - 16*(w-1) -: 16];
            checkOutput($sformatf("word%0d_valid", w), 32'(ui_din_valid), 32'd1);
            checkOutput($sformatf("word%0d_data", w), 32'(ui_din), 32'(expWord));
            checkOutput($sformatf("word%0d_be", w), 32'(ui_din_be), 32'h3);
            if (w == holdWord) begin
                ui_din_full = 1'b1;
                for (int h = 0; h < 5; h++) begin
                    stepCycle();
                    checkOutput($sformatf("hold%0d_data", h), 32'(ui_din), 32'(expWord));
                    checkOutput($sformatf("hold%0d_valid", h), 32'(ui_din_valid), 32'd1);
                end
                ui_din_full = 1'b0;
            end
            stepCycle();
        end
        checkOutput("bubble_valid", 32'(ui_din_valid), 32'd0);
    endtask

    initial begin
        int validSeen;

        applyReset();
        checkOutput("rst_valid", 32'(ui_din_valid), 32'd0);
        checkOutput("rst_din", 32'(ui_din), 32'd0);
        checkOutput("rst_get", 32'(lb_dout_get), 32'd0);
        checkOutput("rst_pkt_cnt", pkt_sent_count, 32'd0);
        checkOutput("rst_drop_cnt", 32'(drop_count), 32'd0);

        // Single packet with latency check, then the same packet with back-pressure.
        mode      = 2'd2;
        ch_enable = 2'b11;
        applyStimulus(2'b01, {88'h0, PKT_T});
        checkOutput("lat_edgeN", 32'(ui_din_valid), 32'd0);
        stepCycle();
        checkOutput("lat_edgeN1", 32'(ui_din_valid), 32'd0);
        stepCycle();
        checkOutput("lat_edgeN2", 32'(ui_din_valid), 32'd1);
        expectPacket(8'h00, PAD_T, -1);
        checkOutput("t1_pkt_cnt", pkt_sent_count, 32'd1);
        applyStimulus(2'b01, {88'h0, PKT_T});
        expectPacket(8'h00, PAD_T, 3);
        checkOutput("t2_pkt_cnt", pkt_sent_count, 32'd2);

        // Two packets per channel queued while idle, then drained round-robin.
        applyReset();
        mode = 2'd0;
        applyStimulus(2'b11, {PKT_C, PKT_A});
        applyStimulus(2'b11, {PKT_D, PKT_B});
        mode = 2'd2;
        expectPacket(8'h00, PAD_A, -1);
        expectPacket(8'h01, PAD_C, -1);
        expectPacket(8'h00, PAD_B, -1);
        expectPacket(8'h01, PAD_D, -1);
        checkOutput("t3_pkt_cnt", pkt_sent_count, 32'd4);

        // Overflow on ch1 under back-pressure; disabled ch0 strobes are ignored.
        applyReset();
        mode        = 2'd2;
        ch_enable   = 2'b10;
        ui_din_full = 1'b1;
        for (int s = 0; s < 6; s++) applyStimulus(2'b11, {PKT_B, PKT_A});
        checkOutput("t4_drop_cnt", 32'(drop_count), 32'd2);
        checkOutput("t4_held_hdr", 32'(ui_din), 32'h0000A501);
        ui_din_full = 1'b0;
        for (int p = 0; p < 4; p++) expectPacket(8'h01, PAD_B, -1);
        validSeen = 0;
        for (int n = 0; n < 15; n++) begin
            if (ui_din_valid) validSeen++;
            stepCycle();
        end
        checkOutput("t4_no_extra", 32'(validSeen), 32'd0);
        checkOutput("t4_pkt_cnt", pkt_sent_count, 32'd4);
        clear_counters = 1'b1;
        stepCycle();
        clear_counters = 1'b0;
        checkOutput("t4_clr_pkt", pkt_sent_count, 32'd0);
        checkOutput("t4_clr_drop", 32'(drop_count), 32'd0);

        // Loopback pass-through, then leaving loopback.
        applyReset();
        ch_enable = 2'b11;
        mode      = 2'd1;
        stepCycle();
        checkOutput("lb_empty_valid", 32'(ui_din_valid), 32'd0);
        lb_dout = 16'h1111; lb_dout_be = 2'b01; lb_dout_empty = 1'b0;
        #1;
        checkOutput("lb1_din", 32'(ui_din), 32'h1111);
        checkOutput("lb1_be", 32'(ui_din_be), 32'h1);
        checkOutput("lb1_valid", 32'(ui_din_valid), 32'd1);
        checkOutput("lb1_get", 32'(lb_dout_get), 32'd1);
        ui_din_full = 1'b1;
        #1;
        checkOutput("lb1_get_full", 32'(lb_dout_get), 32'd0);
        ui_din_full = 1'b0;
        applyStimulus(2'b01, {88'h0, PKT_A});
        lb_dout = 16'h2222; lb_dout_be = 2'b11;
        #1;
        checkOutput("lb2_din", 32'(ui_din), 32'h2222);
        checkOutput("lb2_be", 32'(ui_din_be), 32'h3);
        checkOutput("lb2_get", 32'(lb_dout_get), 32'd1);
        mode = 2'd0;
        #1;
        checkOutput("lb_exit_valid", 32'(ui_din_valid), 32'd0);
        checkOutput("lb_exit_get", 32'(lb_dout_get), 32'd0);
        stepCycle();
        checkOutput("lb_idle_din", 32'(ui_din), 32'd0);
        lb_dout_empty = 1'b1;

        // Reset in the middle of a packet.
        applyReset();
        mode = 2'd2;
        applyStimulus(2'b01, {88'h0, PKT_T});
        expectPacket(8'h00, PAD_T, -1);
        applyStimulus(2'b01, {88'h0, PKT_T});
        for (int n = 0; n < 20 && !ui_din_valid; n++) stepCycle();
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("t6_word2", 32'(ui_din), 32'h000089AB);
        checkOutput("t6_pre_cnt", pkt_sent_count, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(ui_din_valid), 32'd0);
        checkOutput("t6_rst_din", 32'(ui_din), 32'd0);
        checkOutput("t6_rst_be", 32'(ui_din_be), 32'd0);
        checkOutput("t6_rst_cnt", pkt_sent_count, 32'd0);
        stepCycle();
        rst_n = 1'b1;
        validSeen = 0;
        for (int n = 0; n < 10; n++) begin
            if (ui_din_valid) validSeen++;
            stepCycle();
        end
        checkOutput("t6_no_residual", 32'(validSeen), 32'd0);
        applyStimulus(2'b01, {88'h0, PKT_C});
        expectPacket(8'h00, PAD_C, -1);
        checkOutput("t6_pkt_cnt", pkt_sent_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
